// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: evaluates conditional branches, returns a one-cycle
// resolution record to the IF predictor, squashes wrong-path work and counts outcomes.
module branch_resolver #(
  parameter int DATA_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              stall,
  input  logic              branch,
  input  logic              predict,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  input  logic              pred_taken,
  output logic [DATA_W-1:0] old_pc,
  output logic [DATA_W-1:0] old_branch_pc,
  output logic              old_predict,
  output logic              old_actual,
  output logic              old_branch,
  output logic              flush,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  typedef enum logic {IDLE, SQUASH} state_t;

  localparam logic [3:0] SQUASH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state_reg;
  logic [3:0] squash_cnt_reg;
  logic       cond;
  logic       capture;
  logic       mismatch;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (rs1_data == rs2_data);
      3'b001:  cond = (rs1_data != rs2_data);
      3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  cond = (rs1_data <  rs2_data);
      3'b111:  cond = (rs1_data >= rs2_data);
      default: cond = 1'b0;
    endcase
  end

  // Wrong-path instructions during SQUASH are never captured nor counted.
  assign capture  = valid & ~stall & branch & predict & (state_reg == IDLE);
  assign mismatch = cond ^ pred_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      squash_cnt_reg <= '0;
      flush          <= 1'b0;
      old_pc         <= '0;
      old_branch_pc  <= '0;
      old_predict    <= 1'b0;
      old_actual     <= 1'b0;
      old_branch     <= 1'b0;
      br_cnt         <= '0;
      miss_cnt       <= '0;
    end else begin
      // predict/actual forced low without a record so the predictor sees no mismatch
      old_branch  <= capture;
      old_predict <= capture & pred_taken;
      old_actual  <= capture & cond;

      if (capture) begin
        old_branch_pc <= pc;
        old_pc        <= cond ? (pc + imm) : (pc + DATA_W'(4));
        if (br_cnt != {CNT_W{1'b1}})
          br_cnt <= br_cnt + CNT_W'(1);
        if (mismatch && (miss_cnt != {CNT_W{1'b1}}))
          miss_cnt <= miss_cnt + CNT_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (capture && mismatch) begin
            state_reg      <= SQUASH;
            squash_cnt_reg <= SQUASH_LOAD;
            flush          <= 1'b1;
          end
        end
        SQUASH: begin
          if (squash_cnt_reg == 4'd0) begin
            state_reg <= IDLE;
            flush     <= 1'b0;
          end else begin
            squash_cnt_reg <= squash_cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          flush     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: two instances (default, and FLUSH_CYCLES=1/CNT_W=4) checked
// every cycle against an outcome-level model, plus directed literal expectations.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0, stall = 1'b0, branch = 1'b0, predict = 1'b0, pred_taken = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0, pc = '0, imm = '0;

  logic [31:0] o0_pc, o0_bpc, o1_pc, o1_bpc;
  logic        o0_pred, o0_act, o0_br, o0_flush;
  logic        o1_pred, o1_act, o1_br, o1_flush;
  logic [31:0] o0_brc, o0_miss;
  logic [3:0]  o1_brc, o1_miss;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolver #(.DATA_W(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .valid(valid), .stall(stall), .branch(branch), .predict(predict),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .old_pc(o0_pc), .old_branch_pc(o0_bpc), .old_predict(o0_pred),
    .old_actual(o0_act), .old_branch(o0_br), .flush(o0_flush), .br_cnt(o0_brc), .miss_cnt(o0_miss));

  branch_resolver #(.DATA_W(32), .FLUSH_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .valid(valid), .stall(stall), .branch(branch), .predict(predict),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .old_pc(o1_pc), .old_branch_pc(o1_bpc), .old_predict(o1_pred),
    .old_actual(o1_act), .old_branch(o1_br), .flush(o1_flush), .br_cnt(o1_brc), .miss_cnt(o1_miss));

  // ---------------- reference model: per instance, by outcome rules ----------------
  logic [31:0] m_pc[2], m_bpc[2];
  bit          m_pred[2], m_act[2], m_br[2];
  int          m_sq[2];          // remaining flush cycles
  longint      m_brc[2], m_miss[2];

  function automatic int flush_len(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic longint cnt_max(int k);
    return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd15;
  endfunction

  function automatic bit cond_of(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_pc[k] <= '0; m_bpc[k] <= '0; m_pred[k] <= 0; m_act[k] <= 0; m_br[k] <= 0;
        m_sq[k] <= 0; m_brc[k] <= 0; m_miss[k] <= 0;
      end else if (m_sq[k] > 0) begin
        m_sq[k] <= m_sq[k] - 1;
        m_br[k] <= 0; m_pred[k] <= 0; m_act[k] <= 0;
      end else if (valid && !stall && branch && predict) begin
        bit t;
        t = cond_of(funct3, rs1_data, rs2_data);
        m_br[k]   <= 1;
        m_pred[k] <= pred_taken;
        m_act[k]  <= t;
        m_bpc[k]  <= pc;
        m_pc[k]   <= t ? 32'(pc + imm) : 32'(pc + 32'd4);
        m_brc[k]  <= (m_brc[k] + 1 > cnt_max(k)) ? cnt_max(k) : m_brc[k] + 1;
        if (t != pred_taken) begin
          m_miss[k] <= (m_miss[k] + 1 > cnt_max(k)) ? cnt_max(k) : m_miss[k] + 1;
          m_sq[k]   <= flush_len(k);
        end
      end else begin
        m_br[k] <= 0; m_pred[k] <= 0; m_act[k] <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always @(posedge clk) begin
    #2;
    chk("dut0.old_pc", o0_pc, m_pc[0]);
    chk("dut0.old_branch_pc", o0_bpc, m_bpc[0]);
    chk("dut0.old_predict", o0_pred, m_pred[0]);
    chk("dut0.old_actual", o0_act, m_act[0]);
    chk("dut0.old_branch", o0_br, m_br[0]);
    chk("dut0.flush", o0_flush, m_sq[0] > 0);
    chk("dut0.br_cnt", o0_brc, m_brc[0]);
    chk("dut0.miss_cnt", o0_miss, m_miss[0]);
    chk("dut1.old_pc", o1_pc, m_pc[1]);
    chk("dut1.old_branch_pc", o1_bpc, m_bpc[1]);
    chk("dut1.old_predict", o1_pred, m_pred[1]);
    chk("dut1.old_actual", o1_act, m_act[1]);
    chk("dut1.old_branch", o1_br, m_br[1]);
    chk("dut1.flush", o1_flush, m_sq[1] > 0);
    chk("dut1.br_cnt", o1_brc, m_brc[1]);
    chk("dut1.miss_cnt", o1_miss, m_miss[1]);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit s, input bit b, input bit p, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] bb, input logic [31:0] pcv,
                       input logic [31:0] im, input bit pt);
    @(negedge clk);
    valid = v; stall = s; branch = b; predict = p; funct3 = f;
    rs1_data = a; rs2_data = bb; pc = pcv; imm = im; pred_taken = pt;
    $display("txn v=%0b s=%0b b=%0b p=%0b f3=%0d a=%h b=%h pc=%h imm=%h pt=%0b",
             v, s, b, p, f, a, bb, pcv, im, pt);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int flen;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.old_branch", o0_br, 0);
    chk("rst.old_pc", o0_pc, 0);
    chk("rst.flush", o0_flush, 0);
    chk("rst.br_cnt", o0_brc, 0);
    @(negedge clk);
    rst = 1'b1;

    // beq taken, correctly predicted
    drive(1, 0, 1, 1, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1);
    tick();
    chk("t1.old_branch", o0_br, 1);
    chk("t1.old_actual", o0_act, 1);
    chk("t1.old_predict", o0_pred, 1);
    chk("t1.old_pc", o0_pc, 32'h120);
    chk("t1.old_branch_pc", o0_bpc, 32'h100);
    chk("t1.flush", o0_flush, 0);
    chk("t1.br_cnt", o0_brc, 1);
    chk("t1.miss_cnt", o0_miss, 0);
    idle();
    tick();
    chk("t1.pulse_end", o0_br, 0);
    chk("t1.pc_hold", o0_pc, 32'h120);

    // blt signed: -1 < 1 taken, predicted not-taken
    drive(1, 0, 1, 1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 0);
    tick();
    chk("t2.old_actual", o0_act, 1);
    chk("t2.old_pc", o0_pc, 32'h240);
    chk("t2.miss_cnt", o0_miss, 1);
    flen = o0_flush ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      tick();
      if (o0_flush) flen++;
    end
    chk("t2.flush_len", 64'(flen), 2);
    drive(1, 0, 1, 1, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 0);
    tick();
    chk("t2u.old_actual", o0_act, 0);
    chk("t2u.old_pc", o0_pc, 32'h204);
    chk("t2u.flush", o0_flush, 0);
    chk("t2u.br_cnt", o0_brc, 3);

    // mispredict, then branches inside the squash window are dropped
    drive(1, 0, 1, 1, 3'd0, 32'd7, 32'd7, 32'h300, 32'h8, 0);
    tick();
    chk("t3.br_cnt_mis", o0_brc, 4);
    drive(1, 0, 1, 1, 3'd0, 32'd1, 32'd1, 32'h304, 32'h10, 1);
    tick();
    chk("t3.sq1_no_rec", o0_br, 0);
    drive(1, 0, 1, 1, 3'd0, 32'd1, 32'd1, 32'h306, 32'h10, 1);
    tick();
    chk("t3.sq2_no_rec", o0_br, 0);
    chk("t3.br_cnt_sq", o0_brc, 4);
    drive(1, 0, 1, 1, 3'd0, 32'd1, 32'd1, 32'h308, 32'h10, 1);
    tick();
    chk("t3.idle_capture", o0_br, 1);
    chk("t3.bpc", o0_bpc, 32'h308);
    chk("t3.br_cnt", o0_brc, 5);

    // jal and an ALU op
    drive(1, 0, 1, 0, 3'd0, 32'd1, 32'd1, 32'h400, 32'h80, 1);
    tick();
    chk("t4.jal_br", o0_br, 0);
    chk("t4.jal_pred", o0_pred, 0);
    chk("t4.jal_act", o0_act, 0);
    chk("t4.jal_pc", o0_pc, 32'h318);
    drive(1, 0, 0, 1, 3'd0, 32'd1, 32'd1, 32'h404, 32'h80, 1);
    tick();
    chk("t4.alu_br", o0_br, 0);
    chk("t4.alu_cnt", o0_brc, 5);

    // stalled bne resolves on the first unstalled edge
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 1, 3'd1, 32'd1, 32'd2, 32'h500, 32'h30, 1);
      tick();
      chk("t5.stall_no_rec", o0_br, 0);
    end
    drive(1, 0, 1, 1, 3'd1, 32'd1, 32'd2, 32'h500, 32'h30, 1);
    tick();
    chk("t5.rec", o0_br, 1);
    chk("t5.old_pc", o0_pc, 32'h530);
    chk("t5.br_cnt", o0_brc, 6);

    // async reset in the middle of a squash
    drive(1, 0, 1, 1, 3'd0, 32'd3, 32'd3, 32'h600, 32'h8, 0);
    tick();
    chk("t5.sq_flush", o0_flush, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5.rst_flush", o0_flush, 0);
    chk("t5.rst_br_cnt", o0_brc, 0);
    chk("t5.rst_miss_cnt", o0_miss, 0);
    chk("t5.rst_old_branch", o0_br, 0);
    idle();
    idle();
    @(negedge clk);
    rst = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, bb;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      bb = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) : $urandom);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) != 0,
            $urandom_range(0, 4) != 0, 3'($urandom), a, bb, {$urandom} & 32'hFFFF_FFFC,
            $urandom, $urandom_range(0, 1) == 1);
    end

    // saturation of the narrow counters
    idle();
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 1, 3'd0, 32'd9, 32'd9, 32'h700 + 32'(i * 4), 32'h10, 0);
      idle();
    end
    tick();
    chk("t6.br_cnt_sat", o1_brc, 15);
    chk("t6.miss_cnt_sat", o1_miss, 15);
    idle();
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
